// File: rtl/cmp_pkg.sv
// Shared encodings and sizing helpers for the pipelined comparator.
// Imported by every comparator file.
package cmp_pkg;

    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

    localparam int FLAG_LT  = 0;
    localparam int FLAG_EQ  = 1;
    localparam int FLAG_GT  = 2;
    localparam int FLAG_LEQ = 3;
    localparam int NFLAGS   = 4;

    // Returns 0 when the split is illegal so the top can refuse it.
    function automatic int nstages(input int w, input int s);
        if (s < 1 || w < s || (w % s) != 0)
            return 0;
        return w / s;
    endfunction

endpackage

// File: rtl/cmp_slice_stage.sv
// One ripple-carry slice of the pipelined subtractor.
// Purely combinational; the parent registers the carry.
module cmp_slice_stage
    import cmp_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum,
    output logic            cout
);

    logic [BITS:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < BITS; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[BITS];
    end

endmodule

// File: rtl/pipelined_magnitude_comparator.sv
// Carry-pipelined a-b comparator with lt/eq/gt/leq flags.
// Each stage resolves one slice; the last stage owns the output.
module pipelined_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             leq
);

    localparam int NST = (nstages(WIDTH, STAGE_BITS) < 1) ?
                         1 : nstages(WIDTH, STAGE_BITS);
    localparam int SB  = STAGE_BITS;

    if (nstages(WIDTH, STAGE_BITS) < 1) begin : g_bad_split
        $error("WIDTH must be a positive multiple of STAGE_BITS");
    end

    logic             v_q  [NST];
    logic             c_q  [NST];
    logic             s_q  [NST];
    logic [WIDTH-1:0] a_q  [NST];
    logic [WIDTH-1:0] nb_q [NST];
    logic [WIDTH-1:0] d_q  [NST];
    logic [NST-1:0]   load;
    logic [NFLAGS-1:0] flags_q;

    // A stage can load if it or any stage downstream has a hole,
    // or the consumer drains the output this cycle.
    always_comb begin
        load = '0;
        for (int k = 0; k < NST; k++) begin
            load[k] = out_ready;
            for (int j = k; j < NST; j++)
                if (!v_q[j])
                    load[k] = 1'b1;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[NST-1];
    assign diff      = d_q[NST-1];
    assign lt        = flags_q[FLAG_LT];
    assign eq        = flags_q[FLAG_EQ];
    assign gt        = flags_q[FLAG_GT];
    assign leq       = flags_q[FLAG_LEQ];

    for (genvar k = 0; k < NST; k++) begin : g_stage
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_nb;
        logic [WIDTH-1:0] src_d;
        logic             src_c;
        logic             src_s;
        logic             src_v;
        logic [SB-1:0]    sum;
        logic             cout;
        logic [WIDTH-1:0] nxt_d;

        if (k == 0) begin : g_head
            assign src_a  = a;
            assign src_nb = ~b;
            assign src_d  = '0;
            assign src_c  = 1'b1;
            assign src_s  = is_signed;
            assign src_v  = in_valid;
        end else begin : g_body
            assign src_a  = a_q[k-1];
            assign src_nb = nb_q[k-1];
            assign src_d  = d_q[k-1];
            assign src_c  = c_q[k-1];
            assign src_s  = s_q[k-1];
            assign src_v  = v_q[k-1];
        end

        cmp_slice_stage #(
            .BITS(SB)
        ) u_slice (
            .a   (src_a[k*SB +: SB]),
            .b   (src_nb[k*SB +: SB]),
            .cin (src_c),
            .sum (sum),
            .cout(cout)
        );

        assign nxt_d = src_d | (WIDTH'(sum) << (k * SB));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k]  <= 1'b0;
                c_q[k]  <= 1'b0;
                s_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                nb_q[k] <= '0;
                d_q[k]  <= '0;
            end else if (load[k]) begin
                v_q[k] <= src_v;
                if (src_v) begin
                    c_q[k]  <= cout;
                    s_q[k]  <= src_s;
                    a_q[k]  <= src_a;
                    nb_q[k] <= src_nb;
                    d_q[k]  <= nxt_d;
                end
            end
        end

        if (k == NST - 1) begin : g_tail
            logic              a_msb;
            logic              b_msb;
            logic              d_msb;
            logic              ovf;
            logic              lt_c;
            logic              eq_c;
            logic [NFLAGS-1:0] nxt_f;

            // Signed overflow: operands differ in sign and the
            // result sign disagrees with a.
            always_comb begin
                a_msb = src_a[WIDTH-1];
                b_msb = ~src_nb[WIDTH-1];
                d_msb = nxt_d[WIDTH-1];
                ovf   = (a_msb != b_msb) && (d_msb != a_msb);
                lt_c  = (src_s == CMP_SIGNED) ? (d_msb ^ ovf) : ~cout;
                eq_c  = ~|nxt_d;
                nxt_f = '0;
                nxt_f[FLAG_LT]  = lt_c;
                nxt_f[FLAG_EQ]  = eq_c;
                nxt_f[FLAG_GT]  = ~lt_c & ~eq_c;
                nxt_f[FLAG_LEQ] = lt_c | eq_c;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    flags_q <= '0;
                else if (load[k] && src_v)
                    flags_q <= nxt_f;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_magnitude_comparator.sv
// Self-checking bench: directed table, reset/mode/backpressure
// sequences and randomized streams against an arithmetic model.
module tb_pipelined_magnitude_comparator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv   [3];
    logic        ordy [3];
    logic        sg   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        flt  [3];
    logic        feq  [3];
    logic        fgt  [3];
    logic        fle  [3];
    logic [63:0] opa  [3];
    logic [63:0] opb  [3];
    logic [15:0] d16;
    logic [7:0]  d8;
    logic [31:0] d32;

    int total = 0;
    int bad   = 0;

    localparam int W  [3] = '{16, 8, 32};
    localparam int NS [3] = '{4, 1, 4};

    pipelined_magnitude_comparator #(.WIDTH(16), .STAGE_BITS(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(opa[0][15:0]), .b(opb[0][15:0]), .is_signed(sg[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .diff(d16),
        .lt(flt[0]), .eq(feq[0]), .gt(fgt[0]), .leq(fle[0])
    );

    pipelined_magnitude_comparator #(.WIDTH(8), .STAGE_BITS(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(opa[1][7:0]), .b(opb[1][7:0]), .is_signed(sg[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .diff(d8),
        .lt(flt[1]), .eq(feq[1]), .gt(fgt[1]), .leq(fle[1])
    );

    pipelined_magnitude_comparator #(.WIDTH(32), .STAGE_BITS(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(opa[2][31:0]), .b(opb[2][31:0]), .is_signed(sg[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .diff(d32),
        .lt(flt[2]), .eq(feq[2]), .gt(fgt[2]), .leq(fle[2])
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] d;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [63:0] dget(input int s);
        case (s)
            0:       return 64'(d16);
            1:       return 64'(d8);
            default: return 64'(d32);
        endcase
    endfunction

    function automatic logic [3:0] fget(input int s);
        return {flt[s], feq[s], fgt[s], fle[s]};
    endfunction

    // Flags as {lt, eq, gt, leq}, derived from integer values.
    function automatic void model(input int w, input logic [63:0] a,
                                  input logic [63:0] b, input logic s,
                                  output logic [63:0] d,
                                  output logic [3:0] f);
        longint m, ua, ub, sa, sb;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = ua;
        sb = ub;
        if (s && ua >= (longint'(1) << (w - 1)))
            sa = ua - (longint'(1) << w);
        if (s && ub >= (longint'(1) << (w - 1)))
            sb = ub - (longint'(1) << w);
        d = 64'((ua - ub) & m);
        f = {sa < sb, sa == sb, sa > sb, sa <= sb};
    endfunction

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input string n, input logic [15:0] a,
                          input logic [15:0] b, input logic s,
                          input logic [15:0] ed, input logic [3:0] ef);
        int lat;
        iv[0]  = 1'b1;
        opa[0] = 64'(a);
        opb[0] = 64'(b);
        sg[0]  = s;
        #1;
        chk({n, "_rdy"}, 64'(ir[0]), 64'd1);
        tick();
        iv[0] = 1'b0;
        lat = 1;
        while (!ov[0] && lat < 16) begin
            tick();
            lat++;
        end
        chk({n, "_lat"}, 64'(lat), 64'd4);
        chk({n, "_diff"}, 64'(d16), 64'(ed));
        chk({n, "_flags"}, 64'(fget(0)), 64'(ef));
    endtask

    task automatic stream(input int s, input int nb, input bit bp);
        logic [63:0] qd [$];
        logic [3:0]  qf [$];
        logic [63:0] m, ed, pd;
        logic [3:0]  ef;
        logic [4:0]  pf;
        int acc, ret, cyc, r;
        bit pend, stall, sawfull;
        acc = 0; ret = 0; cyc = 0;
        pend = 0; stall = 0; sawfull = 0;
        pd = '0; pf = '0;
        m = (64'd1 << W[s]) - 64'd1;
        iv[s] = 1'b0;
        ordy[s] = 1'b1;
        while (ret < nb && cyc < nb * 20 + 100) begin
            tick();
            if (stall) begin
                chk("hold_diff", dget(s), pd);
                chk("hold_flags", 64'({ov[s], fget(s)}), 64'(pf));
            end
            if (!pend) begin
                if (acc < nb && (bp || $urandom_range(3) != 0)) begin
                    iv[s] = 1'b1;
                    sg[s] = 1'($urandom_range(1));
                    r = $urandom_range(7);
                    opa[s] = {$urandom, $urandom} & m;
                    opb[s] = {$urandom, $urandom} & m;
                    if (r == 0) opb[s] = opa[s];
                    if (r == 1) begin opa[s] = m; opb[s] = '0; end
                    if (r == 2) begin
                        opa[s] = (m >> 1) + 64'd1;
                        opb[s] = m >> 1;
                    end
                end else begin
                    iv[s] = 1'b0;
                end
            end
            ordy[s] = bp ? !(cyc >= 3 && cyc <= 8)
                         : ($urandom_range(3) != 0);
            #1;
            if (!ir[s]) begin
                sawfull = 1;
                chk("full_depth", 64'(acc - ret), 64'(NS[s]));
            end
            if (ov[s] && ordy[s]) begin
                if (qd.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    ed = qd.pop_front();
                    ef = qf.pop_front();
                    chk("str_diff", dget(s), ed);
                    chk("str_flags", 64'(fget(s)), 64'(ef));
                    chk("str_onehot",
                        64'($countones({flt[s], feq[s], fgt[s]})), 64'd1);
                end
                ret++;
            end
            if (iv[s] && ir[s]) begin
                model(W[s], opa[s], opb[s], sg[s], ed, ef);
                qd.push_back(ed);
                qf.push_back(ef);
                acc++;
                pend = 0;
            end else begin
                pend = iv[s];
            end
            stall = ov[s] && !ordy[s];
            pd = dget(s);
            pf = {ov[s], fget(s)};
            cyc++;
        end
        tick();
        iv[s] = 1'b0;
        ordy[s] = 1'b1;
        chk("str_count", 64'(ret), 64'(nb));
        chk("str_left", 64'(qd.size()), 64'd0);
        if (bp)
            chk("bp_in_ready_drop", 64'(sawfull), 64'd1);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; sg[i] = 1'b0;
            opa[i] = '0; opb[i] = '0;
        end
        tbl[0]  = '{16'h0005, 16'hFFFF, 1'b0, 16'h0006, 4'b1001};
        tbl[1]  = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b0101};
        tbl[2]  = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 4'b0010};
        tbl[3]  = '{16'h8000, 16'h7FFF, 1'b1, 16'h0001, 4'b1001};
        tbl[4]  = '{16'h7FFF, 16'h8000, 1'b1, 16'hFFFF, 4'b0010};
        tbl[5]  = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFE, 4'b1001};
        tbl[6]  = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 4'b0010};
        tbl[7]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0101};
        tbl[8]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 4'b0101};
        tbl[9]  = '{16'h0001, 16'h0002, 1'b1, 16'hFFFF, 4'b1001};
        tbl[10] = '{16'h8000, 16'h0000, 1'b0, 16'h8000, 4'b0010};
        tbl[11] = '{16'h0001, 16'h8000, 1'b0, 16'h8001, 4'b1001};
        tbl[12] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1001};

        #2;
        chk("rst_out_valid", 64'({ov[0], ov[1], ov[2]}), 64'd0);
        chk("rst_diff", 64'(d16), 64'd0);
        chk("rst_flags", 64'(fget(0)), 64'd0);
        chk("rst_in_ready", 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++)
            send16($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
                   tbl[i].s, tbl[i].d, tbl[i].f);

        // Same operands, mode flips between consecutive beats.
        tick();
        iv[0] = 1'b1; opa[0] = 64'hFFFF; opb[0] = 64'h0001; sg[0] = 1'b0;
        #1 chk("mode_rdy0", 64'(ir[0]), 64'd1);
        tick();
        sg[0] = 1'b1;
        #1 chk("mode_rdy1", 64'(ir[0]), 64'd1);
        tick();
        iv[0] = 1'b0;
        seen = 0;
        while (!ov[0] && seen < 16) begin
            tick();
            seen++;
        end
        chk("mode_first_flags", 64'(fget(0)), 64'b0010);
        chk("mode_first_diff", 64'(d16), 64'hFFFE);
        tick();
        chk("mode_second_valid", 64'(ov[0]), 64'd1);
        chk("mode_second_flags", 64'(fget(0)), 64'b1001);
        tick();
        tick();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1;
            opa[0] = 64'($urandom_range(16'hFFFF));
            opb[0] = 64'($urandom_range(16'hFFFF));
            tick();
        end
        iv[0] = 1'b0;
        chk("pre_rst_flags_nonzero", 64'(fget(0) != 4'd0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(ov[0]), 64'd0);
        chk("midrst_flags", 64'(fget(0)), 64'd0);
        chk("midrst_diff", 64'(d16), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov[0]) seen++;
        end
        chk("postrst_no_result", 64'(seen), 64'd0);
        send16("postrst", 16'h0010, 16'h0003, 1'b0, 16'h000D, 4'b0010);
        tick();

        stream(0, 10, 1'b1);
        stream(0, 1000, 1'b0);
        stream(1, 10000, 1'b0);
        stream(2, 10000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
